// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running raster timing controller.
// Produces hsync/vsync, display_on, x/y, line/frame strobes and a frame counter,
// all registered and aligned to the same clock edge.
// Ports:
//   clk, rst_n (async active-low), pause (holds frame counter)
//   hsync, vsync, display_on, x[9:0], y[9:0], line_start, frame_start, frame[7:0]
module vga_sync_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pause,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SS   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SE   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SS   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SE   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [9:0] x_q, x_d;
    logic [9:0] y_q, y_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic       de_q, de_d;
    logic       ls_q, ls_d;
    logic       fs_q, fs_d;
    logic [7:0] frame_q, frame_d;

    logic       h_wrap;
    logic [10:0] xw, yw;

    // Strobes are decoded from the next position so that they land in the
    // same cycle as the coordinates they describe.
    always_comb begin
        h_wrap = (x_q == H_LAST);
        x_d    = h_wrap ? 10'd0 : x_q + 10'd1;
        y_d    = y_q;
        if (h_wrap) begin
            y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
        end

        xw = {1'b0, x_d};
        yw = {1'b0, y_d};

        hsync_d = ((xw >= H_SS) && (xw < H_SE)) ? SYNC_POL : ~SYNC_POL;
        vsync_d = ((yw >= V_SS) && (yw < V_SE)) ? SYNC_POL : ~SYNC_POL;
        de_d    = (xw < H_ACT) && (yw < V_ACT);
        ls_d    = (x_d == 10'd0);
        fs_d    = (x_d == 10'd0) && (y_d == 10'd0);

        frame_d = frame_q;
        if (fs_d && !pause) begin
            frame_d = frame_q + 8'd1;
        end
    end

    // Reset values equal the decode of the last raster position, so
    // releasing reset steps cleanly into (0,0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            de_q    <= 1'b0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
            frame_q <= 8'hFF;
        end else begin
            x_q     <= x_d;
            y_q     <= y_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            de_q    <= de_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
            frame_q <= frame_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign display_on  = de_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame       = frame_q;

endmodule
